line_transfer_engine: RTL and testbench
=======================================

# line_transfer_engine

Cache-line transfer initiator for the SRAM memory interface. It accepts one line command (fill or write-back) from the cache and issues `LINE_WORDS` single-word transfers on the memory client port (`transfer_request` / `wait_request` / `read_data_valid`). Fills are issued critical-word-first with wrap inside the line, and each returned word is indexed for the cache line buffer. The block sits between the cache controller and `memory_interface`.

## Interface
Parameters:
- `WORDS_LOG2`, 3, log2 of words per line; `LINE_WORDS = 1 << WORDS_LOG2`; line is `4*LINE_WORDS` bytes.

Ports:
- `clkin` in 1: sole clock, all logic on posedge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: line command present.
- `cmd_ready` out 1: high in IDLE; command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write-back, 0 = fill.
- `cmd_addr` in 32: byte address; bits [WORDS_LOG2+1:2] give the start word; bits [1:0] are ignored.
- `wr_index` out WORDS_LOG2: line-buffer word index for the current write word.
- `wr_word` in 32: line-buffer data at `wr_index`, same cycle (combinational read).
- `rd_valid` out 1: fill word valid this cycle.
- `rd_index` out WORDS_LOG2: word index of `rd_word`.
- `rd_word` out 32: fill data.
- `done` out 1: one-cycle pulse when a command completes.
- `transfer_request` out 1; `address` out 32; `wren` out 1; `wrdata` out 32; `wrmask` out 4: memory request.
- `wait_request` in 1; `read_data_valid` in 1; `read_data` in 32: memory response.

## Operation
- Registers:
  - `state`.
  - `base`: line address, `cmd_addr` with bits [WORDS_LOG2+1:0] cleared.
  - `start`: start word.
  - `issue_cnt` and `ret_cnt`: WORDS_LOG2+1 bits each.
- Word offset for request k is `(start + k) mod LINE_WORDS`. The add truncates to WORDS_LOG2 bits. `address = base | (offset << 2)`, so the address never leaves the line.
- A request is accepted in any cycle with `transfer_request & ~wait_request`. Only an accepted request increments `issue_cnt`.
- IDLE:
  - Outputs: `cmd_ready=1`, `transfer_request=0`, `wren=0`, `wrmask=0`.
  - On accept: latch `base` and `start`, clear both counters, then go to READ (`cmd_write=0`) or WRITE (`cmd_write=1`).
- READ:
  - Drives `transfer_request=1`, `wren=0`, `address` for `issue_cnt`.
  - On acceptance of the last request (`issue_cnt==LINE_WORDS-1`), go to READ_WAIT.
  - Requests may be accepted back-to-back.
- READ_WAIT: `transfer_request=0`; wait for the remaining returns.
- Returns (READ and READ_WAIT only):
  - Each `read_data_valid` drives `rd_valid=1`, `rd_word=read_data`, `rd_index=(start+ret_cnt) mod LINE_WORDS`, and increments `ret_cnt`.
  - When the return makes `ret_cnt` reach LINE_WORDS, go to IDLE and pulse `done` next cycle.
  - Returns in the same cycle as an issue are counted independently.
- WRITE:
  - Drives `transfer_request=1`, `wren=1`, `wrmask=4'hF`, `wrdata=wr_word`, `wr_index=(start+issue_cnt) mod LINE_WORDS`, `address` for that word.
  - After the last acceptance, go to WRITE_WAIT.
- WRITE_WAIT:
  - `transfer_request=0`.
  - Leave once `wait_request==0` is sampled; at that point the last write is committed. Then go to IDLE and pulse `done`.
- `read_data_valid` is ignored in IDLE, WRITE and WRITE_WAIT.
- `rd_valid` is never asserted outside READ/READ_WAIT.
- `cmd_valid` is ignored outside IDLE. Commands do not queue.

## Timing
- Reset (async assert, sync release):
  - `state=IDLE`, counters 0, `base=0`, `start=0`.
  - Outputs: `cmd_ready=1`, `transfer_request=0`, `wren=0`, `wrmask=0`, `address=0`, `rd_valid=0`, `done=0`, `wr_index=0`.
- Reset mid-command abandons the command. Memory returns still in flight after reset are dropped, because the block is in IDLE.
- All request outputs are decoded from registered state and counters; there is no combinational path from `wait_request` to `transfer_request`. The exceptions are `wrdata` (from `wr_word`) and the `rd_*` outputs, which are combinational pass-through of the memory response.
- Command accepted in cycle 0 → first `transfer_request` in cycle 1.
- Fill against a zero-wait, latency-1 memory: requests in cycles 1..L, data in 2..L+1, `done` in L+2, `cmd_ready` high again from cycle L+2.
- `done` is registered. It is high exactly one cycle, the first IDLE cycle. A new command may be accepted in that same cycle.
- `wait_request` high holds `address`, `wrdata` and `wr_index` stable until acceptance.

## Test plan
- Fill, `cmd_addr=0x1000`, memory returns `addr^0xA5A5A5A5` with latency 1 → 8 requests at 0x1000..0x101C in consecutive cycles; `rd_index` 0..7 with matching data; `done` one cycle, 10 cycles after command accept.
- Critical-word fill, `cmd_addr=0x2014` → addresses 0x2014, 0x2018, 0x201C, 0x2000..0x2010; `rd_index` 5,6,7,0..4.
- Write-back, `cmd_addr=0x3008`, line buffer word i = `0x100+i`, `wait_request` high 3 cycles after each write → addresses 0x3008..0x301C then 0x3000..0x3004, `wrdata` 0x102..0x107 then 0x100..0x101, `wrmask=F`; `done` only after the final `wait_request` drop; no `rd_valid`.
- Random `wait_request` stalls during a fill, plus a stray `read_data_valid` in IDLE → each address issued exactly once and held while stalled; exactly 8 `rd_valid`; the stray beat is ignored.
- `reset_n` pulsed low after 3 fill returns, with 2 returns still in flight → outputs at reset values; 0 `rd_valid` and no `done`; a following fill of 0x4000 completes normally.
- `cmd_valid` held high through a fill → second command accepted in the same cycle as `done`; `cmd_ready` low throughout the first command.

Source files
------------

// File: rtl/line_transfer_engine_if.sv
// Memory client port between the line transfer engine (master) and the
// SRAM memory interface (slave): single-word requests with wait and read return.
interface line_transfer_engine_if;
    logic        transfer_request;
    logic [31:0] address;
    logic        wren;
    logic [31:0] wrdata;
    logic [3:0]  wrmask;
    logic        wait_request;
    logic        read_data_valid;
    logic [31:0] read_data;

    modport master (
        output transfer_request, address, wren, wrdata, wrmask,
        input  wait_request, read_data_valid, read_data
    );

    modport slave (
        input  transfer_request, address, wren, wrdata, wrmask,
        output wait_request, read_data_valid, read_data
    );
endinterface

// File: rtl/line_transfer_engine.sv
// Cache-line transfer initiator: turns one fill or write-back command into
// LINE_WORDS single-word memory transfers, critical word first with wrap.
module line_transfer_engine #(
    parameter int unsigned WORDS_LOG2 = 3
) (
    input  logic                  clkin,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    output logic [WORDS_LOG2-1:0] wr_index,
    input  logic [31:0]           wr_word,
    output logic                  rd_valid,
    output logic [WORDS_LOG2-1:0] rd_index,
    output logic [31:0]           rd_word,
    output logic                  done,
    line_transfer_engine_if.master mem
);

    localparam int unsigned LINE_WORDS = 1 << WORDS_LOG2;
    localparam int unsigned CW         = WORDS_LOG2 + 1;
    localparam logic [CW-1:0] LAST     = CW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_WAIT,
        WRITE,
        WRITE_WAIT
    } state_t;

    state_t                state;
    logic [31:0]           base;
    logic [WORDS_LOG2-1:0] start;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         ret_cnt;
    logic                  done_q;

    logic [WORDS_LOG2-1:0] issue_off;
    logic [WORDS_LOG2-1:0] ret_off;
    logic                  in_read;
    logic                  accept;
    logic                  unused_addr_bits;

    // Offsets truncate to WORDS_LOG2 bits so the walk wraps inside the line.
    assign issue_off = start + issue_cnt[WORDS_LOG2-1:0];
    assign ret_off   = start + ret_cnt[WORDS_LOG2-1:0];
    assign in_read   = (state == READ) || (state == READ_WAIT);
    assign accept    = mem.transfer_request & ~mem.wait_request;

    assign unused_addr_bits = ^cmd_addr[1:0];

    assign cmd_ready            = (state == IDLE);
    assign mem.transfer_request = (state == READ) || (state == WRITE);
    assign mem.wren             = (state == WRITE);
    assign mem.wrmask           = (state == WRITE) ? 4'hF : 4'h0;
    assign mem.address          = base | 32'({issue_off, 2'b00});
    assign mem.wrdata           = wr_word;
    assign wr_index             = issue_off;

    assign rd_valid = in_read & mem.read_data_valid;
    assign rd_index = ret_off;
    assign rd_word  = mem.read_data;
    assign done     = done_q;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base      <= '0;
            start     <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base      <= {cmd_addr[31:WORDS_LOG2+2], {(WORDS_LOG2+2){1'b0}}};
                        start     <= cmd_addr[WORDS_LOG2+1:2];
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= cmd_write ? WRITE : READ;
                    end
                end
                READ, READ_WAIT: begin
                    if ((state == READ) && accept) begin
                        issue_cnt <= issue_cnt + CW'(1);
                        if (issue_cnt == LAST) begin
                            state <= READ_WAIT;
                        end
                    end
                    // Issue and return are tracked independently; the final
                    // return always lands after the final issue, so it wins.
                    if (mem.read_data_valid) begin
                        ret_cnt <= ret_cnt + CW'(1);
                        if (ret_cnt == LAST) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        issue_cnt <= issue_cnt + CW'(1);
                        if (issue_cnt == LAST) begin
                            state <= WRITE_WAIT;
                        end
                    end
                end
                WRITE_WAIT: begin
                    if (!mem.wait_request) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_transfer_engine.sv
// Directed bench for line_transfer_engine with a negedge-driven memory model
// (configurable latency and wait_request stall patterns).
module tb_line_transfer_engine;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic        clkin = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  wr_index;
    logic [31:0] wr_word;
    logic        rd_valid;
    logic [2:0]  rd_index;
    logic [31:0] rd_word;
    logic        done;

    line_transfer_engine_if mem ();

    line_transfer_engine #(.WORDS_LOG2(3)) dut (
        .clkin     (clkin),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .wr_index  (wr_index),
        .wr_word   (wr_word),
        .rd_valid  (rd_valid),
        .rd_index  (rd_index),
        .rd_word   (rd_word),
        .done      (done),
        .mem       (mem)
    );

    always #5 clkin = ~clkin;

    // Line buffer: word i holds 0x100 + i.
    assign wr_word = 32'h100 + {29'd0, wr_index};

    int passed = 0;
    int total  = 0;

    // Memory model controls.
    int          lat        = 1;
    int          stall_mode = 0;   // 0 none, 1 random, 2 three cycles after each accept
    int          stall_left = 0;
    bit          stray      = 1'b0;
    logic        pv [4];
    logic [31:0] pd [4];

    initial begin
        mem.wait_request    = 1'b0;
        mem.read_data_valid = 1'b0;
        mem.read_data       = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        forever begin
            @(negedge clkin);
            if (stall_mode == 1) begin
                mem.wait_request = ($urandom_range(0, 2) == 0);
            end else if (stall_left > 0) begin
                mem.wait_request = 1'b1;
                stall_left--;
            end else begin
                mem.wait_request = 1'b0;
            end
            mem.read_data_valid = pv[lat-1];
            mem.read_data       = pd[lat-1];
            if (stray) begin
                mem.read_data_valid = 1'b1;
                mem.read_data       = 32'hDEADBEEF;
                stray               = 1'b0;
            end
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = mem.transfer_request & ~mem.wait_request & ~mem.wren;
            pd[0] = mem.address ^ KEY;
            if (stall_mode == 2 && mem.transfer_request && !mem.wait_request) stall_left = 3;
        end
    end

    // Transaction record filled by run_cmd.
    logic [31:0] q_addr  [16];
    logic [31:0] q_wdata [16];
    logic [3:0]  q_mask  [16];
    int          q_cyc   [16];
    logic [2:0]  r_idx   [16];
    logic [31:0] r_dat   [16];
    int n_req, n_rd, done_cyc, n_done, hold_err, busy_ready;

    task automatic tick;
        @(negedge clkin);
        #1;
    endtask

    // Issues one command (accept cycle = cycle 0) and records bus activity.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input int budget);
        logic        prev_stall;
        logic [31:0] pa;
        logic [31:0] pw;
        logic [2:0]  pi;
        n_req = 0; n_rd = 0; done_cyc = -1; n_done = 0; hold_err = 0; busy_ready = 0;
        prev_stall = 1'b0; pa = '0; pw = '0; pi = '0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        for (int c = 1; c <= budget; c++) begin
            tick;
            if (c == 1) cmd_valid = 1'b0;
            if (prev_stall && (mem.address !== pa || mem.wrdata !== pw || wr_index !== pi)) hold_err++;
            prev_stall = mem.transfer_request & mem.wait_request;
            pa = mem.address; pw = mem.wrdata; pi = wr_index;
            if (mem.transfer_request && !mem.wait_request) begin
                if (n_req < 16) begin
                    q_addr[n_req]  = mem.address;
                    q_wdata[n_req] = mem.wrdata;
                    q_mask[n_req]  = mem.wrmask;
                    q_cyc[n_req]   = c;
                end
                n_req++;
            end
            if (rd_valid) begin
                if (n_rd < 16) begin
                    r_idx[n_rd] = rd_index;
                    r_dat[n_rd] = rd_word;
                end
                n_rd++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end else if (done_cyc < 0 && cmd_ready) begin
                busy_ready++;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else passed++;
        total++; if (mem.transfer_request !== 1'b0) $display("FAIL reset_treq: got %b expected 0", mem.transfer_request); else passed++;
        total++; if (mem.wren !== 1'b0 || mem.wrmask !== 4'h0) $display("FAIL reset_wren_mask: got %b/%h expected 0/0", mem.wren, mem.wrmask); else passed++;
        total++; if (mem.address !== 32'h0) $display("FAIL reset_address: got %h expected 0", mem.address); else passed++;
        total++; if (rd_valid !== 1'b0 || done !== 1'b0 || wr_index !== 3'd0) $display("FAIL reset_misc: rd_valid %b done %b wr_index %0d expected 0 0 0", rd_valid, done, wr_index); else passed++;
        reset_n = 1'b1;
        tick;
        tick;
    endtask

    task automatic test_fill;
        lat = 1; stall_mode = 0;
        run_cmd(1'b0, 32'h1000, 40);
        total++; if (n_req !== 8) $display("FAIL fill_nreq: got %0d expected 8", n_req); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (q_addr[k] !== 32'h1000 + 32'(4 * k) || q_cyc[k] !== k + 1)
                $display("FAIL fill_req[%0d]: got %h@%0d expected %h@%0d", k, q_addr[k], q_cyc[k], 32'h1000 + 32'(4 * k), k + 1);
            else passed++;
        end
        total++; if (n_rd !== 8) $display("FAIL fill_nrd: got %0d expected 8", n_rd); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (r_idx[k] !== 3'(k) || r_dat[k] !== ((32'h1000 + 32'(4 * k)) ^ KEY))
                $display("FAIL fill_rd[%0d]: got %0d/%h expected %0d/%h", k, r_idx[k], r_dat[k], k, (32'h1000 + 32'(4 * k)) ^ KEY);
            else passed++;
        end
        total++; if (done_cyc !== 10 || n_done !== 1) $display("FAIL fill_done: got cycle %0d count %0d expected 10 1", done_cyc, n_done); else passed++;
        total++; if (busy_ready !== 0) $display("FAIL fill_cmd_ready_busy: got %0d expected 0", busy_ready); else passed++;
    endtask

    task automatic test_critical_word;
        int w;
        lat = 1; stall_mode = 0;
        run_cmd(1'b0, 32'h2014, 40);
        total++; if (n_req !== 8 || n_rd !== 8) $display("FAIL cw_counts: got %0d/%0d expected 8/8", n_req, n_rd); else passed++;
        for (int k = 0; k < 8; k++) begin
            w = (5 + k) % 8;
            total++;
            if (q_addr[k] !== 32'h2000 + 32'(4 * w))
                $display("FAIL cw_addr[%0d]: got %h expected %h", k, q_addr[k], 32'h2000 + 32'(4 * w));
            else passed++;
            total++;
            if (r_idx[k] !== 3'(w) || r_dat[k] !== ((32'h2000 + 32'(4 * w)) ^ KEY))
                $display("FAIL cw_rd[%0d]: got %0d/%h expected %0d/%h", k, r_idx[k], r_dat[k], w, (32'h2000 + 32'(4 * w)) ^ KEY);
            else passed++;
        end
        total++; if (done_cyc !== 10 || n_done !== 1) $display("FAIL cw_done: got cycle %0d count %0d expected 10 1", done_cyc, n_done); else passed++;
    endtask

    task automatic test_write_back;
        int w;
        lat = 1; stall_mode = 2; stall_left = 0;
        run_cmd(1'b1, 32'h3008, 80);
        stall_mode = 0;
        total++; if (n_req !== 8) $display("FAIL wb_nreq: got %0d expected 8", n_req); else passed++;
        for (int k = 0; k < 8; k++) begin
            w = (2 + k) % 8;
            total++;
            if (q_addr[k] !== 32'h3000 + 32'(4 * w) || q_wdata[k] !== 32'h100 + 32'(w) || q_mask[k] !== 4'hF || q_cyc[k] !== 1 + 4 * k)
                $display("FAIL wb_req[%0d]: got %h/%h/%h@%0d expected %h/%h/f@%0d", k, q_addr[k], q_wdata[k], q_mask[k], q_cyc[k],
                         32'h3000 + 32'(4 * w), 32'h100 + 32'(w), 1 + 4 * k);
            else passed++;
        end
        total++; if (hold_err !== 0) $display("FAIL wb_hold: got %0d changes expected 0", hold_err); else passed++;
        total++; if (n_rd !== 0) $display("FAIL wb_rd_valid: got %0d expected 0", n_rd); else passed++;
        total++; if (done_cyc !== 34 || n_done !== 1) $display("FAIL wb_done: got cycle %0d count %0d expected 34 1", done_cyc, n_done); else passed++;
    endtask

    task automatic test_random_stall;
        lat = 1; stall_mode = 0;
        stray = 1'b1;
        tick;
        total++; if (rd_valid !== 1'b0 || done !== 1'b0) $display("FAIL stray_beat: rd_valid %b done %b expected 0 0", rd_valid, done); else passed++;
        tick;
        stall_mode = 1;
        run_cmd(1'b0, 32'h6000, 300);
        stall_mode = 0;
        total++; if (n_req !== 8) $display("FAIL rs_nreq: got %0d expected 8", n_req); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (q_addr[k] !== 32'h6000 + 32'(4 * k) || r_idx[k] !== 3'(k) || r_dat[k] !== ((32'h6000 + 32'(4 * k)) ^ KEY))
                $display("FAIL rs_xfer[%0d]: got %h %0d/%h expected %h %0d/%h", k, q_addr[k], r_idx[k], r_dat[k],
                         32'h6000 + 32'(4 * k), k, (32'h6000 + 32'(4 * k)) ^ KEY);
            else passed++;
        end
        total++; if (hold_err !== 0) $display("FAIL rs_hold: got %0d changes expected 0", hold_err); else passed++;
        total++; if (n_rd !== 8 || n_done !== 1) $display("FAIL rs_counts: got rd %0d done %0d expected 8 1", n_rd, n_done); else passed++;
    endtask

    task automatic test_reset_mid_fill;
        int n;
        int late_rd;
        int late_done;
        lat = 2; stall_mode = 0;
        n = 0; late_rd = 0; late_done = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h7000;
        for (int c = 1; c <= 20; c++) begin
            tick;
            cmd_valid = 1'b0;
            if (rd_valid) n++;
            if (n == 3) break;
        end
        total++; if (n !== 3) $display("FAIL rst_prefill: got %0d returns expected 3", n); else passed++;
        // Two returns are still in the memory pipeline at this point.
        reset_n = 1'b0;
        tick;
        total++; if (cmd_ready !== 1'b1 || mem.transfer_request !== 1'b0 || mem.wren !== 1'b0 || mem.wrmask !== 4'h0)
            $display("FAIL rst_ctl: ready %b treq %b wren %b mask %h expected 1 0 0 0", cmd_ready, mem.transfer_request, mem.wren, mem.wrmask);
        else passed++;
        total++; if (mem.address !== 32'h0 || wr_index !== 3'd0 || done !== 1'b0)
            $display("FAIL rst_vals: address %h wr_index %0d done %b expected 0 0 0", mem.address, wr_index, done);
        else passed++;
        if (rd_valid) late_rd++;
        tick;
        if (rd_valid) late_rd++;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (rd_valid) late_rd++;
            if (done) late_done++;
        end
        total++; if (late_rd !== 0 || late_done !== 0) $display("FAIL rst_drop: got rd %0d done %0d expected 0 0", late_rd, late_done); else passed++;
        lat = 1;
        run_cmd(1'b0, 32'h4000, 40);
        total++; if (n_req !== 8 || n_rd !== 8) $display("FAIL rst_refill_counts: got %0d/%0d expected 8/8", n_req, n_rd); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (q_addr[k] !== 32'h4000 + 32'(4 * k) || r_dat[k] !== ((32'h4000 + 32'(4 * k)) ^ KEY))
                $display("FAIL rst_refill[%0d]: got %h/%h expected %h/%h", k, q_addr[k], r_dat[k], 32'h4000 + 32'(4 * k), (32'h4000 + 32'(4 * k)) ^ KEY);
            else passed++;
        end
        total++; if (done_cyc !== 10 || n_done !== 1) $display("FAIL rst_refill_done: got cycle %0d count %0d expected 10 1", done_cyc, n_done); else passed++;
    endtask

    task automatic test_back_to_back;
        int dc;
        int busy;
        int n;
        bit got;
        lat = 1; stall_mode = 0;
        dc = -1; busy = 0; n = 0; got = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1000;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (c == 1) cmd_addr = 32'h5000;
            if (done) begin
                dc = c;
                break;
            end
            if (cmd_ready) busy++;
        end
        total++; if (dc !== 10) $display("FAIL b2b_done_cycle: got %0d expected 10", dc); else passed++;
        total++; if (busy !== 0) $display("FAIL b2b_ready_busy: got %0d expected 0", busy); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_at_done: got %b expected 1", cmd_ready); else passed++;
        tick;
        total++; if (mem.transfer_request !== 1'b1 || mem.address !== 32'h5000 || cmd_ready !== 1'b0)
            $display("FAIL b2b_second_start: treq %b addr %h ready %b expected 1 5000 0", mem.transfer_request, mem.address, cmd_ready);
        else passed++;
        cmd_valid = 1'b0;
        if (rd_valid) n++;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (rd_valid) n++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        total++; if (n !== 8 || got !== 1'b1) $display("FAIL b2b_second_done: got rd %0d done %b expected 8 1", n, got); else passed++;
        tick;
        tick;
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        reset_n   = 1'b0;
        test_reset;
        test_fill;
        test_critical_word;
        test_write_back;
        test_random_stall;
        test_reset_mid_fill;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
